hilo_mul_unit: RTL and testbench

//  Execute-stage HI/LO register file and iterative multiplier. Sits directly downstream of ALU control.

---
 rtl/hilo_pkg.sv | 59 +++++
 rtl/mul_iter_core.sv | 63 ++++++
 rtl/hilo_mul_unit.sv | 157 +++++++++++++++
 tb/tb_hilo_mul_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply unit: ALU control opcodes, FSM
// state encoding and the opcode-to-operation decode helpers.
package hilo_pkg;

    localparam logic [4:0] ALU_MULT       = 5'b00101;
    localparam logic [4:0] ALU_MULTU_MADD = 5'b01100;
    localparam logic [4:0] ALU_MSUB       = 5'b01101;
    localparam logic [4:0] ALU_MUL        = 5'b11000;
    localparam logic [4:0] ALU_MTHI       = 5'b10001;
    localparam logic [4:0] ALU_MTLO       = 5'b10011;
    localparam logic [4:0] ALU_MFHI       = 5'b10000;
    localparam logic [4:0] ALU_MFLO       = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MUL   = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_MFHI  = 4'd8,
        OP_MFLO  = 4'd9
    } op_t;

    // 01100 is shared between multu and madd; Accum picks the accumulate form.
    function automatic op_t decode_op(input logic [4:0] aluctl, input logic accum);
        op_t op;
        case (aluctl)
            ALU_MULT:       op = OP_MULT;
            ALU_MULTU_MADD: op = accum ? OP_MADD : OP_MULTU;
            ALU_MSUB:       op = OP_MSUB;
            ALU_MUL:        op = OP_MUL;
            ALU_MTHI:       op = OP_MTHI;
            ALU_MTLO:       op = OP_MTLO;
            ALU_MFHI:       op = OP_MFHI;
            ALU_MFLO:       op = OP_MFLO;
            default:        op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_mult_class(input op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_MUL);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier
// bits per step into a 64-bit product register.
module mul_iter_core #(
    parameter  int BITS_PER_CYCLE = 4,
    localparam int N              = 32 / BITS_PER_CYCLE,
    localparam int CNT_W          = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic [CNT_W-1:0] cnt,
    output logic [63:0]      prod
);

    logic [63:0]      mcand_reg;
    logic [31:0]      mplier_reg;
    logic [63:0]      prod_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      prod_next;
    logic [63:0]      pp [BITS_PER_CYCLE];

    // One partial product per retired multiplier bit this step.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        prod_next = prod_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            prod_next = prod_next + pp[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_reg  <= 64'd0;
            mplier_reg <= 32'd0;
            prod_reg   <= 64'd0;
            cnt_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= {32'd0, a};
            mplier_reg <= b;
            prod_reg   <= 64'd0;
            cnt_reg    <= CNT_W'(N - 1);
        end else if (step) begin
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
            mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign cnt  = cnt_reg;
    assign prod = prod_reg;

endmodule

// File: rtl/hilo_mul_unit.sv
// Execute-stage HI/LO register file with an iterative multiplier, multiply
// accumulate/subtract, HI/LO moves and the pipeline interlock.
module hilo_mul_unit
    import hilo_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Valid,
    input  logic [4:0]  ALUCtl,
    input  logic        HiLoWrite,
    input  logic        Accum,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int N     = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t           state_reg;
    op_t              op_reg;
    logic             negate_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    op_t              dec_op;
    logic             signed_in;
    logic             mult_in;
    logic             mul_in;
    logic             mthi_in;
    logic             mtlo_in;
    logic             mfhi_in;
    logic             mflo_in;
    logic             op_in_unit;
    logic             stall_raw;
    logic             core_load;
    logic             core_step;
    logic [31:0]      abs_a;
    logic [31:0]      abs_b;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      prod;
    logic [63:0]      prod_signed;
    logic [63:0]      hilo_next;

    always_comb begin
        dec_op     = decode_op(ALUCtl, Accum);
        signed_in  = is_signed_op(dec_op);
        mult_in    = Valid & HiLoWrite & is_mult_class(dec_op);
        mul_in     = Valid & HiLoWrite & (dec_op == OP_MUL);
        mthi_in    = Valid & HiLoWrite & (dec_op == OP_MTHI);
        mtlo_in    = Valid & HiLoWrite & (dec_op == OP_MTLO);
        mfhi_in    = Valid & (dec_op == OP_MFHI);
        mflo_in    = Valid & (dec_op == OP_MFLO);
        op_in_unit = mult_in | mthi_in | mtlo_in | mfhi_in | mflo_in;
        abs_a      = (signed_in & A[31]) ? (32'd0 - A) : A;
        abs_b      = (signed_in & B[31]) ? (32'd0 - B) : B;
        core_load  = (state_reg == ST_IDLE) & mult_in;
        core_step  = (state_reg == ST_MUL);
    end

    mul_iter_core #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_core (
        .clk     (Clk),
        .reset_n (Reset_n),
        .load    (core_load),
        .step    (core_step),
        .a       (abs_a),
        .b       (abs_b),
        .cnt     (cnt),
        .prod    (prod)
    );

    always_comb begin
        prod_signed = negate_reg ? (64'd0 - prod) : prod;
        case (op_reg)
            OP_MADD: hilo_next = {hi_reg, lo_reg} + prod_signed;
            OP_MSUB: hilo_next = {hi_reg, lo_reg} - prod_signed;
            default: hilo_next = prod_signed;
        endcase
    end

    // The mul that is retiring in ACC is the very instruction being presented,
    // so it must be released rather than held again.
    always_comb begin
        case (state_reg)
            ST_IDLE: stall_raw = mul_in;
            ST_MUL:  stall_raw = op_in_unit;
            ST_ACC:  stall_raw = op_in_unit & ~(mul_in & (op_reg == OP_MUL));
            default: stall_raw = 1'b0;
        endcase
    end

    always_comb begin
        Result = 32'd0;
        if (Reset_n) begin
            if ((state_reg == ST_ACC) && (op_reg == OP_MUL)) begin
                Result = prod_signed[31:0];
            end else if (mfhi_in && !stall_raw) begin
                Result = hi_reg;
            end else if (mflo_in && !stall_raw) begin
                Result = lo_reg;
            end
        end
    end

    assign Stall = Reset_n & stall_raw;
    assign Busy  = Reset_n & (state_reg != ST_IDLE);
    assign Done  = Reset_n & (state_reg == ST_ACC);
    assign HI    = hi_reg;
    assign LO    = lo_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_NONE;
            negate_reg <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mult_in) begin
                        op_reg     <= dec_op;
                        negate_reg <= signed_in & (A[31] ^ B[31]);
                        state_reg  <= ST_MUL;
                    end else if (mthi_in) begin
                        hi_reg <= A;
                    end else if (mtlo_in) begin
                        lo_reg <= A;
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        state_reg <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (op_reg != OP_MUL) begin
                        hi_reg <= hilo_next[63:32];
                        lo_reg <= hilo_next[31:0];
                    end
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed bench for hilo_mul_unit: default width plus 1- and 8-bit-per-cycle
// instances sharing the same stimulus for the latency comparison.
module tb_hilo_mul_unit;

    localparam logic [4:0] OPC_MULT  = 5'b00101;
    localparam logic [4:0] OPC_MU_MA = 5'b01100;
    localparam logic [4:0] OPC_MSUB  = 5'b01101;
    localparam logic [4:0] OPC_MUL   = 5'b11000;
    localparam logic [4:0] OPC_MTHI  = 5'b10001;
    localparam logic [4:0] OPC_MTLO  = 5'b10011;
    localparam logic [4:0] OPC_MFHI  = 5'b10000;
    localparam logic [4:0] OPC_MFLO  = 5'b10010;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Valid;
    logic [4:0]  ALUCtl;
    logic        HiLoWrite;
    logic        Accum;
    logic [31:0] A;
    logic [31:0] B;

    logic        Stall, Busy, Done;
    logic [31:0] Result, HI, LO;
    logic        stall_b1, busy_b1, done_b1;
    logic [31:0] result_b1, hi_b1, lo_b1;
    logic        stall_b8, busy_b8, done_b8;
    logic [31:0] result_b8, hi_b8, lo_b8;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    hilo_mul_unit #(.BITS_PER_CYCLE(4)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .ALUCtl(ALUCtl),
        .HiLoWrite(HiLoWrite), .Accum(Accum), .A(A), .B(B),
        .Stall(Stall), .Busy(Busy), .Done(Done), .Result(Result), .HI(HI), .LO(LO)
    );

    hilo_mul_unit #(.BITS_PER_CYCLE(1)) u_dut_b1 (
        .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .ALUCtl(ALUCtl),
        .HiLoWrite(HiLoWrite), .Accum(Accum), .A(A), .B(B),
        .Stall(stall_b1), .Busy(busy_b1), .Done(done_b1), .Result(result_b1),
        .HI(hi_b1), .LO(lo_b1)
    );

    hilo_mul_unit #(.BITS_PER_CYCLE(8)) u_dut_b8 (
        .Clk(Clk), .Reset_n(Reset_n), .Valid(Valid), .ALUCtl(ALUCtl),
        .HiLoWrite(HiLoWrite), .Accum(Accum), .A(A), .B(B),
        .Stall(stall_b8), .Busy(busy_b8), .Done(done_b8), .Result(result_b8),
        .HI(hi_b8), .LO(lo_b8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            $display("pass %s obs=0x%0h", tag, obs);
        end else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic hlw, input logic acc,
                         input logic [31:0] a, input logic [31:0] b);
        Valid = 1'b1; ALUCtl = op; HiLoWrite = hlw; Accum = acc; A = a; B = b;
        #1;
    endtask

    task automatic quiet();
        Valid = 1'b0; ALUCtl = 5'd0; HiLoWrite = 1'b0; Accum = 1'b0; A = 32'd0; B = 32'd0;
        #1;
    endtask

    // Issue in cycle 0 and return positioned in cycle 10 with inputs idle.
    task automatic run_mul(input logic [4:0] op, input logic acc,
                           input logic [31:0] a, input logic [31:0] b);
        drive(op, 1'b1, acc, a, b);
        cyc();
        quiet();
        repeat (9) cyc();
    endtask

    initial begin
        int stalls;
        int done_at1, done_at4, done_at8;
        int lo_at1, lo_at4, lo_at8;

        // Reset: outputs forced low even with a MUL presented
        Reset_n = 1'b0;
        quiet();
        drive(OPC_MUL, 1'b1, 1'b0, 32'd3, 32'd3);
        cyc();
        cyc();
        chk("rst_stall", Stall, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_result", Result, 0);
        quiet();
        Reset_n = 1'b1;
        cyc();
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);

        // 1: reset in the middle of a multiply
        drive(OPC_MTLO, 1'b1, 1'b0, 32'h55, 32'd0);
        cyc();
        quiet();
        chk("t1_lo_pre", LO, 32'h55);
        drive(OPC_MULT, 1'b1, 1'b0, 32'd5, 32'd7);
        cyc();
        quiet();
        cyc();
        cyc();
        chk("t1_busy_mid", Busy, 1);
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        #1;
        chk("t1_busy_after", Busy, 0);
        chk("t1_hi_after", HI, 0);
        chk("t1_lo_after", LO, 0);
        repeat (10) cyc();
        chk("t1_lo_late", LO, 0);
        drive(OPC_MFLO, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t1_mflo", Result, 0);
        chk("t1_mflo_stall", Stall, 0);
        cyc();
        quiet();

        // 2: MULT -3 * 7
        drive(OPC_MULT, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        chk("t2_issue_stall", Stall, 0);
        cyc();
        quiet();
        repeat (7) cyc();
        chk("t2_done_c8", Done, 0);
        cyc();
        chk("t2_done_c9", Done, 1);
        chk("t2_busy_c9", Busy, 1);
        cyc();
        chk("t2_hi", HI, 32'hFFFF_FFFF);
        chk("t2_lo", LO, 32'hFFFF_FFEB);
        chk("t2_busy_c10", Busy, 0);

        // 3: MADD then MSUB on a preset HI:LO
        drive(OPC_MTHI, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc();
        drive(OPC_MTLO, 1'b1, 1'b0, 32'h10, 32'd0);
        cyc();
        quiet();
        chk("t3_hi_pre", HI, 0);
        chk("t3_lo_pre", LO, 32'h10);
        run_mul(OPC_MU_MA, 1'b1, 32'd4, 32'd5);
        chk("t3_madd_hi", HI, 0);
        chk("t3_madd_lo", LO, 32'h24);
        run_mul(OPC_MSUB, 1'b0, 32'd6, 32'd6);
        chk("t3_msub_hi", HI, 0);
        chk("t3_msub_lo", LO, 0);

        // Signed corner: most negative squared
        run_mul(OPC_MULT, 1'b0, 32'h8000_0000, 32'h8000_0000);
        chk("corner_hi", HI, 32'h4000_0000);
        chk("corner_lo", LO, 0);

        // 4: MULTU max squared with MFHI right behind it
        drive(OPC_MU_MA, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t4_issue_stall", Stall, 0);
        cyc();
        drive(OPC_MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        stalls = 0;
        for (int c = 1; c <= 9; c++) begin
            if (Stall === 1'b1) stalls++;
            cyc();
        end
        chk("t4_stall_cycles", stalls, 9);
        chk("t4_stall_c10", Stall, 0);
        chk("t4_mfhi", Result, 32'hFFFF_FFFE);
        cyc();
        quiet();
        chk("t4_lo", LO, 32'h1);

        // 5: MUL holds in EX, releases with the product in ACC
        drive(OPC_MUL, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0001);
        stalls = 0;
        for (int c = 0; c <= 8; c++) begin
            if (Stall === 1'b1) stalls++;
            cyc();
        end
        chk("t5_stall_cycles", stalls, 9);
        chk("t5_stall_c9", Stall, 0);
        chk("t5_done_c9", Done, 1);
        chk("t5_result", Result, 32'h0001_0000);
        cyc();
        quiet();
        chk("t5_hi_kept", HI, 32'hFFFF_FFFE);
        chk("t5_lo_kept", LO, 32'h1);
        chk("t5_busy", Busy, 0);

        // Unrecognised code and unqualified multiply are ignored
        drive(5'b00000, 1'b1, 1'b0, 32'd1, 32'd1);
        chk("ign_stall", Stall, 0);
        cyc();
        chk("ign_busy", Busy, 0);
        drive(OPC_MULT, 1'b0, 1'b0, 32'd2, 32'd3);
        cyc();
        quiet();
        chk("nohlw_busy", Busy, 0);

        // 6: MTHI/MTLO back to back
        drive(OPC_MTHI, 1'b1, 1'b0, 32'h1234, 32'd0);
        chk("t6_mthi_stall", Stall, 0);
        cyc();
        drive(OPC_MTLO, 1'b1, 1'b0, 32'h5678, 32'd0);
        chk("t6_mtlo_stall", Stall, 0);
        chk("t6_hi", HI, 32'h1234);
        cyc();
        quiet();
        chk("t6_lo", LO, 32'h5678);

        // Latency across BITS_PER_CYCLE = 1, 4, 8
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        drive(OPC_MULT, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        cyc();
        quiet();
        done_at1 = -1; done_at4 = -1; done_at8 = -1;
        lo_at1 = -1; lo_at4 = -1; lo_at8 = -1;
        for (int c = 1; c <= 40; c++) begin
            if (done_b1 === 1'b1 && done_at1 < 0) done_at1 = c;
            if (Done    === 1'b1 && done_at4 < 0) done_at4 = c;
            if (done_b8 === 1'b1 && done_at8 < 0) done_at8 = c;
            if (lo_b1 === 32'hFFFF_FFEB && lo_at1 < 0) lo_at1 = c;
            if (LO    === 32'hFFFF_FFEB && lo_at4 < 0) lo_at4 = c;
            if (lo_b8 === 32'hFFFF_FFEB && lo_at8 < 0) lo_at8 = c;
            cyc();
        end
        chk("lat_b1_done", done_at1, 33);
        chk("lat_b1_lo", lo_at1, 34);
        chk("lat_b4_done", done_at4, 9);
        chk("lat_b4_lo", lo_at4, 10);
        chk("lat_b8_done", done_at8, 5);
        chk("lat_b8_lo", lo_at8, 6);
        chk("lat_b1_hi", hi_b1, 32'hFFFF_FFFF);
        chk("lat_b8_hi", hi_b8, 32'hFFFF_FFFF);
        chk("lat_b1_busy", busy_b1, 0);
        chk("lat_b8_busy", busy_b8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
